stopwatch_counter: RTL
======================

# stopwatch_counter

Four-digit BCD stopwatch core feeding the multiplexed seven-segment display stage. It counts prescaled clock ticks from 0000 to 9999 under start/stop/clear control and presents one BCD nibble plus one enable per digit. Leading zeros are blanked through the enables. Its outputs connect one-to-one to the display stage's data_0..data_3 and en_0..en_3 inputs; digit 0 is the leftmost (most significant) position.

## Interface
- TICK_DIV, default 1000000: clk_i cycles per count step; legal range ≥ 1.
- clk_i  input  1  system clock; all state changes on its rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  start/resume request, level, already synchronised and debounced; acts on its rising edge only.
- stop_i  input  1  pause request, level; acts on its rising edge only.
- clear_i  input  1  clear request, level; acts on its rising edge only.
- data_0_o..data_3_o  output  4 each  BCD digits: thousands, hundreds, tens, units.
- en_0_o..en_3_o  output  1 each  digit enables with leading-zero blanking.
- running_o  output  1  high while in RUN.
- overflow_o  output  1  high while in OVF.

## Operation
- Edge detect:
  - One register per control input holds its previous sample.
  - Rising edge = input 1 and previous sample 0, evaluated at the current edge.
  - A held-high input produces exactly one action.
- Priority when edges coincide: clear > stop > start.
- States and transitions:
  - IDLE, count 0000:
    - start edge -> RUN, prescaler = 0.
    - stop edge ignored.
  - RUN:
    - prescaler counts 0..TICK_DIV-1 and wraps to 0.
    - On the edge where prescaler == TICK_DIV-1 the BCD count increments.
    - stop edge -> PAUSE.
    - start edge ignored.
  - PAUSE:
    - prescaler and count hold.
    - start edge -> RUN, resuming with the held prescaler value (no restart of the partial step).
  - OVF:
    - count holds 9999.
    - start and stop edges ignored.
  - clear edge in any state -> IDLE, count 0000, prescaler 0. Clear wins over a coincident tick.
- BCD increment:
  - Units 9 -> 0 carries into tens; same rule for tens -> hundreds -> thousands.
  - Each digit stays in 0..9 and never holds A..F.
- Saturation:
  - A tick at 9999 leaves the count at 9999 (no wrap) and enters OVF.
  - OVF is left only by clear or reset.
- Leading-zero blanking:
  - en_3_o = 1 always.
  - en_2_o = (d0|d1|d2) != 0.
  - en_1_o = (d0|d1) != 0.
  - en_0_o = d0 != 0.
  - data outputs always carry the true digit value, blanked or not.

## Timing
- Reset values: all data 0, en_0..en_3 = 0,0,0,1, running_o 0, overflow_o 0, state IDLE, prescaler 0, edge registers 0.
- Reset is asynchronous assert; logic resumes on the first clk_i edge after rst_n_i rises.
- Reset mid-count discards everything.
- Control latency:
  - An input rising before edge N (previous sample 0) takes effect at edge N.
  - running_o and overflow_o are registered and reflect the new state after edge N.
- Count cadence:
  - The first increment after entering RUN from IDLE occurs TICK_DIV edges after the entering edge.
  - Further increments follow every TICK_DIV edges while in RUN.
  - TICK_DIV = 1 increments on every RUN edge.
- Data and enable outputs change on the increment edge; enables are decoded combinationally from the registered digits with no extra latency.
- Entering OVF: overflow_o rises and running_o falls on the same edge as the saturating tick.

## Test plan
- Reset, TICK_DIV=4:
  - Hold rst_n_i low, then release with no control activity.
  - Required: data 0,0,0,0, en 0001, running_o 0, overflow_o 0, stable for 20 cycles.
- Start and count, TICK_DIV=4:
  - Pulse start_i, run 40 cycles.
  - Required: count reaches 0010 exactly 40 edges after the start edge.
  - Required: en goes 0001 -> 0011 at the 10th increment.
  - Required: holding start_i high for all 40 cycles gives the same result.
- Pause and resume, TICK_DIV=4:
  - Start, stop 2 cycles after an increment, wait 50 cycles, then start.
  - Required: count frozen during the wait.
  - Required: the next increment comes 2 cycles after resume (prescaler retained).
- Carry and saturation, TICK_DIV=1:
  - Start and run 10000 edges.
  - Required: count passes 0999 -> 1000 with en 0111 -> 1111.
  - Required: count stops at 9999 with overflow_o 1 and running_o 0.
  - Required: further start/stop edges are ignored.
- Coincident events:
  - In RUN, assert clear_i and stop_i rising on the same edge as a tick.
  - Required: IDLE, count 0000, en 0001, no increment.
- Asynchronous reset mid-count:
  - At count 0357, drop rst_n_i between edges.
  - Required: outputs go to reset values before the next clk_i edge.

Source files
------------

// File: rtl/stopwatch_counter.sv
// Four-digit BCD stopwatch: prescaled tick counter with start/stop/clear edge
// control, 9999 saturation and leading-zero blanking for the display stage.

module stopwatch_digit (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit
);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)          digit <= 4'd0;
    else if (clr)          digit <= 4'd0;
    else if (inc)          digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  end
endmodule

module stopwatch_counter #(
  parameter int TICK_DIV = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       clear_i,
  output logic [3:0] data_0_o,
  output logic [3:0] data_1_o,
  output logic [3:0] data_2_o,
  output logic [3:0] data_3_o,
  output logic       en_0_o,
  output logic       en_1_o,
  output logic       en_2_o,
  output logic       en_3_o,
  output logic       running_o,
  output logic       overflow_o
);
  localparam int NUM_DIG = 4;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_OVF} state_t;

  state_t  state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic start_q, stop_q, clear_q;
  logic start_e, stop_e, clear_e;
  logic tick, bump, all_nine;
  logic running_q, overflow_q;

  // dig[0] is units, dig[3] thousands
  logic [NUM_DIG-1:0][3:0] dig;
  logic [NUM_DIG-1:0]      nine;
  logic [NUM_DIG-1:0]      inc;

  assign start_e = start_i & ~start_q;
  assign stop_e  = stop_i  & ~stop_q;
  assign clear_e = clear_i & ~clear_q;

  assign tick     = (state == S_RUN) && (presc == PMAX);
  assign all_nine = &nine;
  assign bump     = tick && !all_nine && !clear_e;

  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dig
      assign nine[g] = (dig[g] == 4'd9);
      if (g == 0) begin : g_lsd
        assign inc[g] = bump;
      end else begin : g_upper
        assign inc[g] = inc[g-1] & nine[g-1];
      end
      stopwatch_digit u_digit (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr     (clear_e),
        .inc     (inc[g]),
        .digit   (dig[g])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      presc      <= '0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      clear_q    <= 1'b0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      start_q    <= start_i;
      stop_q     <= stop_i;
      clear_q    <= clear_i;
      running_q  <= (state_nxt == S_RUN);
      overflow_q <= (state_nxt == S_OVF);
    end
  end

  // Prescaler advances on every RUN edge, including the one that pauses,
  // so a resume continues the partial step where it left off.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    if (clear_e) begin
      state_nxt = S_IDLE;
      presc_nxt = '0;
    end else begin
      unique case (state)
        S_IDLE: if (start_e) begin
          state_nxt = S_RUN;
          presc_nxt = '0;
        end
        S_RUN: begin
          presc_nxt = tick ? '0 : presc + PW'(1);
          if (tick && all_nine) state_nxt = S_OVF;
          else if (stop_e)      state_nxt = S_PAUSE;
        end
        S_PAUSE: if (start_e) state_nxt = S_RUN;
        S_OVF:   state_nxt = S_OVF;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign data_0_o   = dig[3];
  assign data_1_o   = dig[2];
  assign data_2_o   = dig[1];
  assign data_3_o   = dig[0];
  assign en_0_o     = |dig[3];
  assign en_1_o     = |{dig[3], dig[2]};
  assign en_2_o     = |{dig[3], dig[2], dig[1]};
  assign en_3_o     = 1'b1;
  assign running_o  = running_q;
  assign overflow_o = overflow_q;
endmodule
